// File: rtl/cdc_sync_pkg.sv
// Shared constants for the multi-channel pulse synchroniser: edge-mode
// encodings and the synchroniser depth limit.
package cdc_sync_pkg;

  typedef enum int {
    EDGE_ANY  = 0,
    EDGE_RISE = 1,
    EDGE_FALL = 2
  } edge_mode_e;

  localparam int SYNC_STAGES_MAX = 4;

endpackage

// File: rtl/cdc_sync_chan.sv
// One channel: synchroniser chain, history flop, edge qualification and,
// when CDC_PULSE_SYNC_STICKY_EN is defined, the pending/overrun flags.
module cdc_sync_chan
  import cdc_sync_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic toggle,
  input  logic evt_ack,
  input  logic ovr_clr,
  output logic syn_pulse,
  output logic syn_level,
  output logic evt_pending,
  output logic evt_overrun
);

  logic hist;
  logic edge_det;

  if (SYNC_STAGES > 0) begin : g_chain
    logic [SYNC_STAGES-1:0] chain;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        chain <= '0;
      end else begin
        chain[0] <= toggle;
        for (int i = 1; i < SYNC_STAGES; i++) chain[i] <= chain[i-1];
      end
    end

    assign syn_level = chain[SYNC_STAGES-1];
    assign edge_det  = syn_level ^ hist;
  end else begin : g_direct
    // Combinational path from toggle, so reset has to mask it explicitly.
    assign syn_level = toggle;
    assign edge_det  = reset & (syn_level ^ hist);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) hist <= 1'b0;
    else        hist <= syn_level;
  end

  always_comb begin
    syn_pulse = edge_det;
    if (EDGE_MODE == int'(EDGE_RISE))      syn_pulse = edge_det & syn_level;
    else if (EDGE_MODE == int'(EDGE_FALL)) syn_pulse = edge_det & ~syn_level;
  end

`ifdef CDC_PULSE_SYNC_STICKY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      evt_pending <= 1'b0;
      evt_overrun <= 1'b0;
    end else begin
      if (syn_pulse)    evt_pending <= 1'b1;
      else if (evt_ack) evt_pending <= 1'b0;
      // A new event landing on an unacknowledged one beats a clear.
      if (syn_pulse && evt_pending && !evt_ack) evt_overrun <= 1'b1;
      else if (ovr_clr)                         evt_overrun <= 1'b0;
    end
  end
`else
  logic unused_strobes;
  assign unused_strobes = evt_ack ^ ovr_clr;
  assign evt_pending    = 1'b0;
  assign evt_overrun    = 1'b0;
`endif

endmodule

// File: rtl/cdc_pulse_sync_mc.sv
// Multi-channel edge-to-pulse synchroniser into clk; optional sticky
// pending/overrun flags are compiled in by CDC_PULSE_SYNC_STICKY_EN.
module cdc_pulse_sync_mc
  import cdc_sync_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] toggle,
  input  logic [NUM_CH-1:0] evt_ack,
  input  logic [NUM_CH-1:0] ovr_clr,
  output logic [NUM_CH-1:0] syn_pulse,
  output logic [NUM_CH-1:0] syn_level,
  output logic [NUM_CH-1:0] evt_pending,
  output logic [NUM_CH-1:0] evt_overrun
);

  if (NUM_CH < 1 || NUM_CH > 32) begin : g_bad_num_ch
    $fatal(1, "cdc_pulse_sync_mc: NUM_CH must be 1..32");
  end
  if (SYNC_STAGES < 0 || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
    $fatal(1, "cdc_pulse_sync_mc: SYNC_STAGES must be 0..4");
  end
  if (EDGE_MODE < int'(EDGE_ANY) || EDGE_MODE > int'(EDGE_FALL)) begin : g_bad_mode
    $fatal(1, "cdc_pulse_sync_mc: EDGE_MODE must be 0..2");
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    cdc_sync_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .EDGE_MODE   (EDGE_MODE)
    ) u_chan (
      .clk         (clk),
      .reset       (reset),
      .toggle      (toggle[ch]),
      .evt_ack     (evt_ack[ch]),
      .ovr_clr     (ovr_clr[ch]),
      .syn_pulse   (syn_pulse[ch]),
      .syn_level   (syn_level[ch]),
      .evt_pending (evt_pending[ch]),
      .evt_overrun (evt_overrun[ch])
    );
  end

endmodule

// File: tb/tb_cdc_pulse_sync_mc.sv
// Directed bench for cdc_pulse_sync_mc across edge modes, depths and widths;
// sticky expectations follow CDC_PULSE_SYNC_STICKY_EN.
module tb_cdc_pulse_sync_mc;

`ifdef CDC_PULSE_SYNC_STICKY_EN
  localparam logic STICKY = 1'b1;
`else
  localparam logic STICKY = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [3:0]  tog, ack, clr;
  logic [31:0] tog_w, ack_w, clr_w;

  logic [3:0]  p_any, l_any, pend, ovr;
  logic [3:0]  p_rise, l_rise, pend_r, ovr_r;
  logic [3:0]  p_fall, l_fall, pend_f, ovr_f;
  logic [3:0]  p_s0, l_s0, pend_s, ovr_s;
  logic [31:0] p_w, l_w, pend_w, ovr_w;

  int n_checks = 0;
  int n_fail   = 0;
  int c_any[4], c_rise[4], c_fall[4], c_w[32], exp_w[32];

  cdc_pulse_sync_mc u_dut (
    .clk(clk), .reset(reset), .toggle(tog), .evt_ack(ack), .ovr_clr(clr),
    .syn_pulse(p_any), .syn_level(l_any), .evt_pending(pend), .evt_overrun(ovr));

  cdc_pulse_sync_mc #(.EDGE_MODE(1)) u_rise (
    .clk(clk), .reset(reset), .toggle(tog), .evt_ack(ack), .ovr_clr(clr),
    .syn_pulse(p_rise), .syn_level(l_rise), .evt_pending(pend_r), .evt_overrun(ovr_r));

  cdc_pulse_sync_mc #(.EDGE_MODE(2)) u_fall (
    .clk(clk), .reset(reset), .toggle(tog), .evt_ack(ack), .ovr_clr(clr),
    .syn_pulse(p_fall), .syn_level(l_fall), .evt_pending(pend_f), .evt_overrun(ovr_f));

  cdc_pulse_sync_mc #(.SYNC_STAGES(0)) u_s0 (
    .clk(clk), .reset(reset), .toggle(tog), .evt_ack(ack), .ovr_clr(clr),
    .syn_pulse(p_s0), .syn_level(l_s0), .evt_pending(pend_s), .evt_overrun(ovr_s));

  cdc_pulse_sync_mc #(.NUM_CH(32)) u_wide (
    .clk(clk), .reset(reset), .toggle(tog_w), .evt_ack(ack_w), .ovr_clr(clr_w),
    .syn_pulse(p_w), .syn_level(l_w), .evt_pending(pend_w), .evt_overrun(ovr_w));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      c_any[i]  += int'(p_any[i]);
      c_rise[i] += int'(p_rise[i]);
      c_fall[i] += int'(p_fall[i]);
    end
    for (int i = 0; i < 32; i++) c_w[i] += int'(p_w[i]);
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 4; i++) begin
      c_any[i] = 0; c_rise[i] = 0; c_fall[i] = 0;
    end
    for (int i = 0; i < 32; i++) begin
      c_w[i] = 0; exp_w[i] = 0;
    end
  endtask

  initial begin
    logic [3:0]  vecs[5];
    logic [3:0]  prev;
    logic [31:0] mask;

    vecs = '{4'b0101, 4'b0110, 4'b0110, 4'b1001, 4'b0000};
    reset = 1'b0; tog = '0; ack = '0; clr = '0;
    tog_w = '0; ack_w = '0; clr_w = '0;
    clear_counts();

    // Reset state of every instance
    repeat (3) tick();
    chk("rst_pulse", {p_any, p_rise, p_fall, p_s0}, 0);
    chk("rst_level", {l_any, l_rise, l_fall, l_s0}, 0);
    chk("rst_flags", {pend, ovr, pend_r, ovr_r, pend_f, ovr_f, pend_s, ovr_s}, 0);
    chk("rst_wide", p_w | l_w | pend_w | ovr_w, 0);
    reset = 1'b1;
    repeat (3) tick();

    // ch0 rise: pulse after the second edge, one cycle wide
    tog[0] = 1'b1;
    #1 chk("s0_rise_same_cycle", p_s0, 4'b0001);
    tick(); chk("any_rise_e1", p_any, 4'b0000);
    tick(); chk("any_rise_e2", p_any, 4'b0001);
    chk("mode_rise_on_rise", p_rise, 4'b0001);
    chk("mode_fall_on_rise", p_fall, 4'b0000);
    chk("level_after_rise", l_any, 4'b0001);
    tick(); chk("any_rise_e3", p_any, 4'b0000);

    // ch0 fall
    tog[0] = 1'b0;
    #1 chk("s0_fall_same_cycle", p_s0, 4'b0001);
    tick(); chk("any_fall_e1", p_any, 4'b0000);
    tick(); chk("any_fall_e2", p_any, 4'b0001);
    chk("mode_rise_on_fall", p_rise, 4'b0000);
    chk("mode_fall_on_fall", p_fall, 4'b0001);
    tick(); chk("any_fall_e3", p_any, 4'b0000);

    // ch2 0->1->0, ten cycles apart
    clear_counts();
    tog[2] = 1'b1;
    repeat (10) tick();
    tog[2] = 1'b0;
    repeat (10) tick();
    chk("ch2_rise_count", c_rise[2], 1);
    chk("ch2_fall_count", c_fall[2], 1);
    chk("ch2_any_count", c_any[2], 2);
    chk("ch0_quiet_count", c_any[0], 0);

    // Zero-stage: pulse = toggle ^ previous-cycle toggle
    prev = tog;
    for (int k = 0; k < 5; k++) begin
      tog = vecs[k];
      #1;
      chk($sformatf("s0_pulse_v%0d", k), p_s0, vecs[k] ^ prev);
      chk($sformatf("s0_level_v%0d", k), l_s0, vecs[k]);
      prev = vecs[k];
      tick();
    end
    repeat (4) tick();

    // Sticky flags on ch1
    ack = 4'hF; clr = 4'hF;
    tick();
    ack = '0; clr = '0;
    tick();
    chk("sticky_cleared", {pend, ovr}, 0);
    tog[1] = 1'b1;
    repeat (4) tick();
    chk("pend_first", pend[1], STICKY);
    chk("ovr_first", ovr[1], 1'b0);
    tog[1] = 1'b0;
    repeat (4) tick();
    chk("pend_second", pend[1], STICKY);
    chk("ovr_second", ovr[1], STICKY);
    clr[1] = 1'b1;
    tick();
    clr = '0;
    chk("ovr_after_clr", ovr[1], 1'b0);
    chk("pend_after_clr", pend[1], STICKY);
    tog[1] = 1'b1;
    tick(); tick();
    chk("pulse_for_ack", p_any, 4'b0010);
    ack[1] = 1'b1;
    tick();
    ack = '0;
    chk("pend_ack_pulse", pend[1], STICKY);
    chk("ovr_ack_pulse", ovr[1], 1'b0);
    ack[1] = 1'b1;
    tick();
    ack = '0;
    chk("pend_ack_only", pend[1], 1'b0);
    tog[1] = 1'b0;
    repeat (4) tick();
    tog[1] = 1'b1;
    tick(); tick();
    clr[1] = 1'b1;
    tick();
    clr = '0;
    chk("ovr_wins_over_clr", ovr[1], STICKY);
    tog[1] = 1'b0;
    repeat (4) tick();

    // Reset one cycle after a toggle change discards the event
    clear_counts();
    tog[3] = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("midrst_pulse", {p_any, p_rise, p_fall, p_s0}, 0);
    chk("midrst_level", {l_any, l_rise, l_fall}, 0);
    chk("midrst_flags", {pend, ovr}, 0);
    tog[3] = 1'b0;
    tick();
    reset = 1'b1;
    repeat (6) tick();
    chk("midrst_no_pulse", c_any[3] + c_rise[3] + c_fall[3], 0);

    // Toggle held high through reset release gives one pulse
    reset = 1'b0;
    tog[0] = 1'b1;
    tick();
    chk("held_level_in_rst", l_any, 4'b0000);
    tick();
    reset = 1'b1;
    tick(); chk("held_e1", p_any, 4'b0000);
    tick(); chk("held_e2", p_any, 4'b0001);
    chk("held_e2_rise", p_rise, 4'b0001);
    chk("held_e2_fall", p_fall, 4'b0000);
    tick(); chk("held_e3", p_any, 4'b0000);
    tog[0] = 1'b0;
    repeat (4) tick();

    // 32 channels, random toggles spaced three cycles
    clear_counts();
    for (int n = 0; n < 40; n++) begin
      mask = $urandom;
      tog_w = tog_w ^ mask;
      for (int i = 0; i < 32; i++) exp_w[i] += int'(mask[i]);
      repeat (3) tick();
    end
    repeat (4) tick();
    for (int i = 0; i < 32; i++) chk($sformatf("wide_ch%0d", i), c_w[i], exp_w[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
